// File: rtl/capture_sequencer.sv
// Capture sequencer: arms on a capture request, optionally waits for a SYSREF-aligned
// sync pulse, then routes selected ADC streams onto readout buffers for len_i beats.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for capture_i with a non-zero length
// ARM   | waiting for sync_i; the wait timer expiring sets timeout_o
// RUN   | forwarding selected ADC beats; counting buffer-0 beats
// DONE  | final beat is on the buffers; one-cycle done_o pulse
module capture_sequencer #(
    parameter int NCHAN         = 8,
    parameter int NBUF          = 4,
    parameter int DW            = 128,
    parameter int LENW          = 16,
    parameter int ALIGN_TIMEOUT = 65535
) (
    input  logic                  aclk,
    input  logic                  aclk_rst,
    input  logic                  capture_i,
    input  logic                  abort_i,
    input  logic                  sync_i,
    input  logic                  align_en_i,
    input  logic [LENW-1:0]       len_i,
    input  logic [NBUF*3-1:0]     sel_i,
    input  logic [NCHAN*DW-1:0]   adc_tdata_i,
    input  logic [NCHAN-1:0]      adc_tvalid_i,
    output logic [NBUF*DW-1:0]    buf_tdata_o,
    output logic [NBUF-1:0]       buf_tvalid_o,
    input  logic [NBUF-1:0]       buf_tready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [NBUF-1:0]       overflow_o,
    output logic                  timeout_o,
    output logic [LENW-1:0]       beat_count_o
);

    // The wait timer is a down-counter loaded with ALIGN_TIMEOUT-1; reaching zero
    // without sync_i marks the last permitted ARM cycle.
    localparam int TW = (ALIGN_TIMEOUT < 2) ? 1 : $clog2(ALIGN_TIMEOUT);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(ALIGN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [LENW-1:0]     r_len;
    logic [NBUF*3-1:0]   r_sel;
    logic [TW-1:0]       r_wait;
    logic [LENW-1:0]     r_beat;
    logic [NBUF*DW-1:0]  r_tdata;
    logic [NBUF-1:0]     r_tvalid;
    logic [NBUF-1:0]     r_ovf;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout;

    logic [DW-1:0]       w_sel_data [NBUF];
    logic [NBUF-1:0]     w_sel_valid;
    logic                w_beat_inc;
    logic                w_last;

    // Out-of-range selects fall through with zero data and no valid.
    always_comb begin
        for (int b = 0; b < NBUF; b++) begin
            w_sel_data[b]  = '0;
            w_sel_valid[b] = 1'b0;
            for (int c = 0; c < NCHAN; c++) begin
                if (int'(r_sel[3*b +: 3]) == c) begin
                    w_sel_data[b]  = adc_tdata_i[DW*c +: DW];
                    w_sel_valid[b] = adc_tvalid_i[c];
                end
            end
        end
    end

    assign w_beat_inc = w_sel_valid[0] && (r_beat != '1);
    assign w_last     = w_beat_inc && ((r_beat + LENW'(1)) == r_len);

    always_ff @(posedge aclk) begin
        if (aclk_rst) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_sel     <= '0;
            r_wait    <= '0;
            r_beat    <= '0;
            r_tdata   <= '0;
            r_tvalid  <= '0;
            r_ovf     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_tdata  <= '0;
            r_tvalid <= '0;
            // Beats are never held; an unaccepted beat is dropped and flagged.
            r_ovf    <= r_ovf | (r_tvalid & ~buf_tready_i);

            case (r_state)
                ST_IDLE: begin
                    if (capture_i && !abort_i && (len_i != '0)) begin
                        r_len     <= len_i;
                        r_sel     <= sel_i;
                        r_ovf     <= '0;
                        r_timeout <= 1'b0;
                        r_beat    <= '0;
                        r_wait    <= TIMEOUT_LOAD;
                        r_busy    <= 1'b1;
                        r_state   <= align_en_i ? ST_ARM : ST_RUN;
                    end
                end

                ST_ARM: begin
                    if (abort_i) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (sync_i) begin
                        r_state <= ST_RUN;
                    end else if (r_wait == '0) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait - TW'(1);
                    end
                end

                ST_RUN: begin
                    if (abort_i) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        for (int b = 0; b < NBUF; b++) begin
                            r_tdata[DW*b +: DW] <= w_sel_data[b];
                        end
                        r_tvalid <= w_sel_valid;
                        if (w_beat_inc) begin
                            r_beat <= r_beat + LENW'(1);
                        end
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign buf_tdata_o  = r_tdata;
    assign buf_tvalid_o = r_tvalid;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign overflow_o   = r_ovf;
    assign timeout_o    = r_timeout;
    assign beat_count_o = r_beat;

endmodule
